// File: rtl/seg_scan_ctrl.sv
// Scanned 7-segment controller: latches a display value, runs each digit through one shared
// external BCD decoder, then commits all digits at once, with optional whole-display blinking.
module seg_scan_ctrl #(
   parameter int unsigned NDIG      = 6,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*NDIG-1:0]   load_data,
   input  logic [NDIG-1:0]     load_blank,
   input  logic                blink_en,
   output logic [3:0]          dec_bcd,
   input  logic [6:0]          dec_seg,
   output logic [7*NDIG-1:0]   hex
);

   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned CW = $clog2(BLINK_DIV);

   localparam logic [IW-1:0]     LastIdx  = IW'(NDIG - 1);
   localparam logic [CW-1:0]     CntMax   = CW'(BLINK_DIV - 1);
   localparam logic [7*NDIG-1:0] AllOff   = {NDIG{7'h7F}};

   typedef enum logic [1:0] {StIdle, StScan, StCommit} state_t;

   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic [4*NDIG-1:0]   data_q;
   logic [NDIG-1:0]     blank_q;
   logic [7*NDIG-1:0]   shadow_q;
   logic [7*NDIG-1:0]   disp_q;
   logic [CW-1:0]       blink_cnt_q;
   logic                blink_phase_q;

   logic [IW-1:0]       idx_inc;
   logic [3:0]          nib_next;
   logic [6:0]          seg_cur;

   // Blanked digits never look at dec_seg, so an undefined decoder result cannot leak in.
   always_comb begin
      idx_inc  = idx_q + IW'(1);
      nib_next = 4'h0;
      seg_cur  = 7'h7F;
      for (int i = 0; i < NDIG; i++) begin
         if (IW'(i) == idx_q && !blank_q[i]) begin
            seg_cur = dec_seg;
         end
         if (i > 0 && IW'(i) == idx_inc) begin
            nib_next = data_q[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         data_q     <= '0;
         blank_q    <= '0;
         shadow_q   <= AllOff;
         disp_q     <= AllOff;
         load_ready <= 1'b1;
         dec_bcd    <= 4'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load_valid) begin
                  data_q     <= load_data;
                  blank_q    <= load_blank;
                  idx_q      <= '0;
                  dec_bcd    <= load_data[3:0];
                  load_ready <= 1'b0;
                  state_q    <= StScan;
               end
            end
            StScan: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (IW'(i) == idx_q) begin
                     shadow_q[7*i +: 7] <= seg_cur;
                  end
               end
               if (idx_q == LastIdx) begin
                  dec_bcd <= 4'h0;
                  state_q <= StCommit;
               end else begin
                  idx_q   <= idx_inc;
                  dec_bcd <= nib_next;
               end
            end
            StCommit: begin
               disp_q     <= shadow_q;
               idx_q      <= '0;
               load_ready <= 1'b1;
               state_q    <= StIdle;
            end
            default: begin
               state_q    <= StIdle;
               load_ready <= 1'b1;
               dec_bcd    <= 4'h0;
            end
         endcase
      end
   end

   // On the commit edge hex takes the shadow directly so the new value shows without delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         hex           <= AllOff;
      end else begin
         if (blink_cnt_q == CntMax) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + CW'(1);
         end
         if (blink_en && blink_phase_q) begin
            hex <= AllOff;
         end else if (state_q == StCommit) begin
            hex <= shadow_q;
         end else begin
            hex <= disp_q;
         end
      end
   end

endmodule
